// File: rtl/qspi_mem_ctrl_if.sv
// Request/response bus between the control unit (master) and qspi_mem_ctrl (slave).
// Carries the burst request handshake, write-byte feed, read-byte return and completion status.
interface qspi_mem_ctrl_if #(
  parameter int ADDRESS_WIDTH = 24,
  parameter int NUM_DEVICES   = 3,
  parameter int MAX_BURST     = 4
);
  localparam int DEV_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  localparam int LEN_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [DEV_W-1:0]         req_dev;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [LEN_W-1:0]         req_len;
  logic [7:0]               wr_data;
  logic                     wr_data_ready;
  logic [7:0]               rd_data;
  logic                     rd_valid;
  logic                     done;
  logic                     err;

  modport master (
    output req_valid, req_write, req_dev, req_addr, req_len, wr_data,
    input  req_ready, wr_data_ready, rd_data, rd_valid, done, err
  );

  modport slave (
    input  req_valid, req_write, req_dev, req_addr, req_len, wr_data,
    output req_ready, wr_data_ready, rd_data, rd_valid, done, err
  );
endinterface

// File: rtl/qspi_mem_ctrl.sv
// Quad-SPI memory controller: one burst request -> CMD/ADDR/[DUMMY]/DATA on one chip select.
// Define QSPI_MEM_CTRL_POLL_EN to poll the status register (cmd 05) after every write.
module qspi_mem_ctrl #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 24,
  parameter int NUM_DEVICES    = 3,
  parameter int MAX_BURST      = 4,
  parameter int DUMMY_CYCLES   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  qspi_mem_ctrl_if.slave         bus,
  input  logic [3:0]             spi_data_in,
  output logic [3:0]             spi_data_out,
  output logic [3:0]             spi_data_oe,
  output logic                   spi_clk_out,
  output logic [NUM_DEVICES-1:0] spi_select
);
  localparam int DEV_W     = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  localparam int LEN_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int ADDR_NIBS = ADDRESS_WIDTH / 4;
  localparam int CNT_W     = 8;

  if (DATA_BUS_WIDTH != 8) begin : g_bad_data_width
    $error("qspi_mem_ctrl: DATA_BUS_WIDTH must be 8");
  end
  if ((ADDRESS_WIDTH % 4) != 0 || ADDRESS_WIDTH < 4) begin : g_bad_addr_width
    $error("qspi_mem_ctrl: ADDRESS_WIDTH must be a positive multiple of 4");
  end
  if (NUM_DEVICES < 1 || NUM_DEVICES > 8) begin : g_bad_num_devices
    $error("qspi_mem_ctrl: NUM_DEVICES must be 1..8");
  end
  if (MAX_BURST < 1 || (MAX_BURST & (MAX_BURST - 1)) != 0) begin : g_bad_max_burst
    $error("qspi_mem_ctrl: MAX_BURST must be a power of 2");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RD_DATA,
    S_WR_DATA,
`ifdef QSPI_MEM_CTRL_POLL_EN
    S_DESEL_POLL,
    S_POLL_CMD,
    S_POLL_DATA,
`endif
    S_DESEL
  } state_t;

  state_t                   state_q, state_d;
  logic                     phase_q, phase_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         byte_q, byte_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [DEV_W-1:0]         dev_q, dev_d;
  logic                     write_q, write_d;
  logic                     err_q, err_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               wbuf_q, wbuf_d;
  logic [3:0]               hi_q, hi_d;
  logic [7:0]               rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     wr_rdy;
  logic                     sel_active;
  logic [7:0]               cmd_byte;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      byte_q     <= '0;
      len_q      <= '0;
      dev_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wbuf_q     <= '0;
      hi_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      len_q      <= len_d;
      dev_q      <= dev_d;
      write_q    <= write_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wbuf_q     <= wbuf_d;
      hi_q       <= hi_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign cmd_byte = write_q ? 8'h02 : 8'h0B;

  // phase_q is the SPI clock level; every nibble state flips it, so a nibble ends when phase_q=1
  always_comb begin
    state_d    = state_q;
    phase_d    = 1'b0;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    len_d      = len_q;
    dev_d      = dev_q;
    write_d    = write_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wbuf_d     = wbuf_q;
    hi_d       = hi_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_rdy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          dev_d   = bus.req_dev;
          len_d   = bus.req_len;
          byte_d  = '0;
          cnt_d   = '0;
          if (bus.req_write) begin
            wbuf_d = bus.wr_data;
            wr_rdy = 1'b1;
          end
          err_d   = (int'(bus.req_dev) >= NUM_DEVICES);
          state_d = (int'(bus.req_dev) >= NUM_DEVICES) ? S_DESEL : S_CMD;
        end
      end
      S_CMD: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          addr_d = addr_q << 4;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ADDR_NIBS - 1)) begin
            cnt_d = '0;
            if (write_q)               state_d = S_WR_DATA;
            else if (DUMMY_CYCLES > 0) state_d = S_DUMMY;
            else                       state_d = S_RD_DATA;
          end
        end
      end
      S_DUMMY: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = S_RD_DATA;
          end
        end
      end
      S_RD_DATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 1'b1;
          if (!cnt_q[0]) begin
            hi_d = spi_data_in;
          end else begin
            rd_data_d  = {hi_q, spi_data_in};
            rd_valid_d = 1'b1;
            if (byte_q == len_q) begin
              cnt_d   = '0;
              state_d = S_DESEL;
            end else begin
              byte_d = byte_q + 1'b1;
            end
          end
        end
      end
      S_WR_DATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q[0]) begin
            if (byte_q == len_q) begin
              cnt_d = '0;
`ifdef QSPI_MEM_CTRL_POLL_EN
              state_d = S_DESEL_POLL;
`else
              state_d = S_DESEL;
`endif
            end else begin
              byte_d = byte_q + 1'b1;
              wbuf_d = bus.wr_data;
              wr_rdy = 1'b1;
            end
          end
        end
      end
`ifdef QSPI_MEM_CTRL_POLL_EN
      S_DESEL_POLL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_POLL_CMD;
        end
      end
      S_POLL_CMD: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_POLL_DATA;
          end
        end
      end
      S_POLL_DATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 1'b1;
          if (!cnt_q[0]) begin
            hi_d = spi_data_in;
          end else begin
            // Busy bit set: stay selected and read status again
            cnt_d = '0;
            if (!spi_data_in[0]) state_d = S_DESEL;
          end
        end
      end
`endif
      S_DESEL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    spi_data_oe  = 4'h0;
    spi_data_out = 4'h0;
    sel_active   = 1'b0;
    case (state_q)
      S_CMD: begin
        spi_data_oe  = 4'hF;
        spi_data_out = cnt_q[0] ? cmd_byte[3:0] : cmd_byte[7:4];
        sel_active   = 1'b1;
      end
      S_ADDR: begin
        spi_data_oe  = 4'hF;
        spi_data_out = addr_q[ADDRESS_WIDTH-1 -: 4];
        sel_active   = 1'b1;
      end
      S_WR_DATA: begin
        spi_data_oe  = 4'hF;
        spi_data_out = cnt_q[0] ? wbuf_q[3:0] : wbuf_q[7:4];
        sel_active   = 1'b1;
      end
      S_DUMMY, S_RD_DATA: sel_active = 1'b1;
`ifdef QSPI_MEM_CTRL_POLL_EN
      S_POLL_CMD: begin
        spi_data_oe  = 4'hF;
        spi_data_out = cnt_q[0] ? 4'h5 : 4'h0;
        sel_active   = 1'b1;
      end
      S_POLL_DATA: sel_active = 1'b1;
`endif
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < NUM_DEVICES; gi++) begin : g_sel
    assign spi_select[gi] = ~(sel_active && (dev_q == DEV_W'(gi)));
  end

  assign spi_clk_out       = phase_q;
  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.wr_data_ready = wr_rdy;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.done          = (state_q == S_DESEL) && (cnt_q == CNT_W'(1));
  assign bus.err           = bus.done && err_q;
endmodule
